// File: rtl/uart_program_loader_pkg.sv
// Shared types and constants for the UART program loader.
// Frame: MAGIC, 4-byte LE word count, LE data words, XOR checksum.
package uart_program_loader_pkg;

    typedef enum logic [2:0] {
        WAIT_MAGIC,
        LEN,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam logic [7:0] MAGIC_DEF = 8'hA5;
    localparam int LEN_BYTES = 4;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/uart_program_loader_if.sv
// Byte stream in from uart_rx and memory port A out of the loader.
// master = loader side, slave = environment (uart_rx + memory mux).
interface uart_program_loader_if;

    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        mem_owner;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;

    modport master (
        input  rx_valid, rx_byte,
        output mem_owner, mem_en, mem_we, mem_addr, mem_din
    );

    modport slave (
        output rx_valid, rx_byte,
        input  mem_owner, mem_en, mem_we, mem_addr, mem_din
    );

endinterface

// File: rtl/uart_program_loader_word_assembler.sv
// Packs LSB-first bytes into 32-bit words; word_ready_o marks
// the byte that completes a word, word_o is valid alongside it.
module loader_word_assembler
    import uart_program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_ready_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q;
    logic [31:0] word_q;

    assign word_o = {byte_i, word_q[31:8]};
    assign word_ready_o = byte_valid_i
        && (cnt_q == 2'(WORD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (!reset || clear_i) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else if (byte_valid_i) begin
            cnt_q  <= cnt_q + 2'd1;
            word_q <= word_o;
        end
    end

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: receives a framed program image over UART, writes it
// to memory port A, then releases port A and the core reset.
module uart_program_loader
    import uart_program_loader_pkg::*;
#(
    parameter logic [31:0] LOAD_BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS      = 1048576,
    parameter int unsigned TIMEOUT_CLKS   = 1000000,
    parameter logic [7:0]  MAGIC          = MAGIC_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_program_loader_if.master bus,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  load_error,
    output logic [31:0]           words_loaded
);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] len_q, len_d, len_nxt;
    logic [7:0]  chk_q, chk_d;
    logic [31:0] words_q, words_d;
    logic [31:0] tmo_q, tmo_d;
    logic        en_q, en_d;
    logic [3:0]  we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] din_q, din_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        own_q, cpu_rst_q;
    logic        asm_clr, asm_rdy;
    logic [31:0] asm_word;
    logic        rx_magic;

    assign rx_magic = bus.rx_valid && (bus.rx_byte == MAGIC);
    assign len_nxt  = {bus.rx_byte, len_q[31:8]};

    loader_word_assembler u_asm (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (asm_clr),
        .byte_valid_i (bus.rx_valid && (state_q == DATA)),
        .byte_i       (bus.rx_byte),
        .word_ready_o (asm_rdy),
        .word_o       (asm_word)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        chk_d   = chk_q;
        words_d = words_q;
        tmo_d   = '0;
        en_d    = 1'b0;
        we_d    = 4'h0;
        addr_d  = addr_q;
        din_d   = din_q;
        done_d  = done_q;
        err_d   = err_q;
        asm_clr = 1'b0;
        unique case (state_q)
            WAIT_MAGIC, ERROR: begin
                if (rx_magic) begin
                    state_d = LEN;
                    idx_d   = '0;
                    chk_d   = '0;
                    words_d = '0;
                    err_d   = 1'b0;
                    asm_clr = 1'b1;
                end
            end
            LEN: begin
                if (bus.rx_valid) begin
                    len_d = len_nxt;
                    idx_d = idx_q + 2'd1;
                    chk_d = chk_q ^ bus.rx_byte;
                    if (idx_q == 2'(LEN_BYTES - 1)) begin
                        if (len_nxt > 32'(MAX_WORDS))
                            state_d = ERROR;
                        else if (len_nxt == '0)
                            state_d = CHECK;
                        else
                            state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (bus.rx_valid)
                    chk_d = chk_q ^ bus.rx_byte;
                if (asm_rdy) begin
                    en_d    = 1'b1;
                    we_d    = 4'hF;
                    addr_d  = LOAD_BASE_ADDR
                            + {words_q[29:0], 2'b00};
                    din_d   = asm_word;
                    words_d = words_q + 32'd1;
                    if (words_d == len_q)
                        state_d = CHECK;
                end
            end
            CHECK: begin
                if (bus.rx_valid)
                    state_d = (bus.rx_byte == chk_q)
                            ? DONE : ERROR;
            end
            DONE: ;
            default: state_d = WAIT_MAGIC;
        endcase
        // Idle watchdog only while a frame is in flight
        if (state_q inside {LEN, DATA, CHECK}
            && !bus.rx_valid) begin
            tmo_d = tmo_q + 32'd1;
            if (tmo_d >= 32'(TIMEOUT_CLKS))
                state_d = ERROR;
        end
        if (state_d == ERROR)
            err_d = 1'b1;
        if (state_d == DONE)
            done_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= WAIT_MAGIC;
            idx_q     <= '0;
            len_q     <= '0;
            chk_q     <= '0;
            words_q   <= '0;
            tmo_q     <= '0;
            en_q      <= 1'b0;
            we_q      <= 4'h0;
            addr_q    <= '0;
            din_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            own_q     <= 1'b1;
            cpu_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            chk_q     <= chk_d;
            words_q   <= words_d;
            tmo_q     <= tmo_d;
            en_q      <= en_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            done_q    <= done_d;
            err_q     <= err_d;
            own_q     <= (state_q != DONE);
            cpu_rst_q <= (state_q != DONE);
        end
    end

    assign bus.mem_owner = own_q;
    assign bus.mem_en    = en_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_din   = din_q;
    assign cpu_reset     = cpu_rst_q;
    assign load_done     = done_q;
    assign load_error    = err_q;
    assign words_loaded  = words_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Scoreboard bench for uart_program_loader: expected memory writes
// are queued as bytes are sent and retired by a write monitor.
module tb_uart_program_loader;

    localparam int TMO = 50;
    localparam logic [31:0] BASE = 32'h0000_0000;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_reset, load_done, load_error;
    logic [31:0] words_loaded;

    int n_tests = 0;
    int n_fail  = 0;
    wr_t exp_q[$];
    logic [31:0] img[$];

    uart_program_loader_if bus ();

    uart_program_loader #(
        .LOAD_BASE_ADDR (BASE),
        .TIMEOUT_CLKS   (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.master),
        .cpu_reset    (cpu_reset),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.mem_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexp_wr", bus.mem_addr, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", bus.mem_addr, e.a);
                check("wr_data", bus.mem_din, e.d);
                check("wr_we", {28'd0, bus.mem_we}, 32'hF);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.rx_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] flip,
                              input int gap);
        logic [7:0]  c;
        logic [31:0] n;
        logic [31:0] w;
        c = 8'h00;
        n = img.size();
        send_byte(8'hA5);
        for (int i = 0; i < 4; i++) begin
            if (gap > 0) idle(gap);
            c ^= n[8*i +: 8];
            send_byte(n[8*i +: 8]);
        end
        for (int k = 0; k < img.size(); k++) begin
            w = img[k];
            exp_q.push_back('{BASE + 32'(4 * k), w});
            for (int i = 0; i < 4; i++) begin
                if (gap > 0) idle(gap);
                c ^= w[8*i +: 8];
                send_byte(w[8*i +: 8]);
            end
        end
        if (gap > 0) idle(gap);
        send_byte(c ^ flip);
        idle(1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cpu_rst"}, {31'd0, cpu_reset}, 32'd1);
        check({tag, "_owner"}, {31'd0, bus.mem_owner}, 32'd1);
        check({tag, "_en"}, {31'd0, bus.mem_en}, 32'd0);
        check({tag, "_we"}, {28'd0, bus.mem_we}, 32'd0);
        check({tag, "_addr"}, bus.mem_addr, 32'd0);
        check({tag, "_din"}, bus.mem_din, 32'd0);
        check({tag, "_done"}, {31'd0, load_done}, 32'd0);
        check({tag, "_err"}, {31'd0, load_error}, 32'd0);
        check({tag, "_words"}, words_loaded, 32'd0);
    endtask

    task automatic check_done(input string tag,
                              input logic [31:0] nw);
        check({tag, "_done"}, {31'd0, load_done}, 32'd1);
        check({tag, "_rst_lag"}, {31'd0, cpu_reset}, 32'd1);
        check({tag, "_err"}, {31'd0, load_error}, 32'd0);
        idle(1);
        check({tag, "_cpu_rst"}, {31'd0, cpu_reset}, 32'd0);
        check({tag, "_owner"}, {31'd0, bus.mem_owner}, 32'd0);
        check({tag, "_words"}, words_loaded, nw);
        idle(3);
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int waited;
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'h00;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check_reset_vals("rst");

        // 1: basic two-word frame, spaced bytes
        img = '{32'h1234_5678, 32'hDEAD_BEEF};
        send_frame(8'h00, 1);
        check_done("t1", 32'd2);

        // 2: bad checksum, then good 1-word frame
        do_reset();
        send_frame(8'h01, 0);
        idle(2);
        check("t2_err", {31'd0, load_error}, 32'd1);
        check("t2_done", {31'd0, load_done}, 32'd0);
        check("t2_cpu_rst", {31'd0, cpu_reset}, 32'd1);
        check("t2_owner", {31'd0, bus.mem_owner}, 32'd1);
        check("t2_pending", 32'(exp_q.size()), 32'd0);
        img = '{32'hCAFE_F00D};
        send_frame(8'h00, 0);
        check_done("t2b", 32'd1);

        // 3: junk before magic, zero-word frame
        do_reset();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h13);
        idle(1);
        img = {};
        send_frame(8'h00, 0);
        check_done("t3", 32'd0);

        // 4: length above limit
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h00);
        idle(1);
        check("t4_err", {31'd0, load_error}, 32'd1);
        check("t4_done", {31'd0, load_done}, 32'd0);
        idle(TMO + 10);
        check("t4_cpu_rst", {31'd0, cpu_reset}, 32'd1);

        // 5a: timeout after two data bytes
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        idle(1);
        check("t5_no_err_yet", {31'd0, load_error}, 32'd0);
        waited = 0;
        while (load_error !== 1'b1 && waited < 4 * TMO) begin
            idle(1);
            waited++;
        end
        check("t5_tmo_err", {31'd0, load_error}, 32'd1);
        check("t5_tmo_window",
              32'(waited > TMO - 5 && waited < TMO + 5), 32'd1);

        // 5b: reset mid-DATA after two writes
        do_reset();
        img = '{32'h0102_0304, 32'hA0B0_C0D0, 32'h5555_AAAA};
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back('{BASE + 32'(4 * k), img[k]});
            for (int i = 0; i < 4; i++)
                send_byte(img[k][8*i +: 8]);
        end
        send_byte(8'h77);
        idle(2);
        check("t5_pre_words", words_loaded, 32'd2);
        do_reset();
        check_reset_vals("t5_mid");
        img = '{32'h0BAD_F00D};
        send_frame(8'h00, 0);
        check_done("t5c", 32'd1);

        // 6: back-to-back bytes across write cycles
        do_reset();
        img = '{32'h1111_2222, 32'h3333_4444, 32'h89AB_CDEF};
        send_frame(8'h00, 0);
        check_done("t6", 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
